// File: rtl/bcd_pkg.sv
// Purpose: shared types and constants for the binary-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    // A digit at or above this value would reach 10 or more after the next shift.
    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;

    // Number of decimal digits needed to print the largest value of a width-bit
    // unsigned number.
    function automatic int digits_for_width(input int width);
        longint unsigned maxv;
        int d;
        maxv = (64'd1 << width) - 64'd1;
        d = 1;
        for (int i = 0; i < 20; i++) begin
            if (maxv >= 64'd10) begin
                maxv = maxv / 64'd10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Purpose: double-dabble digit correction, adds 3 to a BCD digit that is >= 5.
// Latency: purely combinational.
// Backpressure: none.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    // A digit is at most 9 before its shift, so 4-bit add cannot carry out.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= ADJ_THRESH) begin
            digit_out = digit_in + 4'd3;
        end
    end

endmodule

// File: rtl/product_bcd_converter.sv
// Purpose: sequential shift-add-3 binary-to-BCD converter for the multiplier product.
//          Optional leading-zero blanking of digit_en under macro LEADING_ZERO_BLANK_EN.
// Latency: IN_WIDTH+1 cycles start-to-done; start ignored while busy, no queuing.
module product_bcd_converter
    import bcd_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [IN_WIDTH-1:0]           product_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]             digit_en
);

    localparam int SW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(IN_WIDTH + 1);

    if (digits_for_width(IN_WIDTH) > DIGITS) begin : g_digits_too_small
        $error("product_bcd_converter: DIGITS too small for IN_WIDTH");
    end

    state_t              state;
    logic [IN_WIDTH-1:0] bin_q;
    logic [SW-1:0]       scratch_q;
    logic [SW-1:0]       scratch_adj;
    logic [CW-1:0]       cnt_q;
    logic [SW+IN_WIDTH-1:0] shift_nxt;
    logic [SW-1:0]       scratch_nxt;
    logic [IN_WIDTH-1:0] bin_nxt;
    logic                last_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_in  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Corrected scratch and the binary operand shift left together as one register.
    always_comb begin
        shift_nxt   = {scratch_adj, bin_q} << 1;
        scratch_nxt = shift_nxt[SW+IN_WIDTH-1:IN_WIDTH];
        bin_nxt     = shift_nxt[IN_WIDTH-1:0];
        last_shift  = (cnt_q == CW'(IN_WIDTH - 1));
    end

    // Conversion FSM: capture on start, IN_WIDTH shifts, one done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_q     <= product_in;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_nxt;
                    bin_q     <= bin_nxt;
                    cnt_q     <= cnt_q + CW'(1);
                    if (last_shift) begin
                        bcd_out <= scratch_nxt;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode directly from the state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic seen_nz;

    // Enable a digit when it or any more significant digit is nonzero; ones always on.
    always_comb begin
        digit_en = '0;
        seen_nz  = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen_nz     = seen_nz | (|bcd_out[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
            digit_en[i] = seen_nz;
        end
        digit_en[0] = 1'b1;
    end
`else
    assign digit_en = '1;
`endif

endmodule
